sdram_req_sched: RTL and testbench

Round-robin request scheduler that shares the SDRAM read/write engine between up to NUM_REQ client ports (frame writers, readers, DMA). It sits between the clients and the SDRAM top-level controller, serialises burst requests into single trigger/length/address commands, and returns per-client completion. It watches each burst for a missing completion and flags a timeout. The SDRAM top handles refresh arbitration internally.

---
 rtl/sdram_pkg.sv | 18 +
 rtl/sdram_rr_pick.sv | 25 ++
 rtl/sdram_req_sched.sv | 119 +++++++++++
 tb/tb_sdram_req_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: scheduler state encoding, address field split and default limits.
package sdram_pkg;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_ISSUE = 5'b00010,
    S_WAIT  = 5'b00100,
    S_DONE  = 5'b01000,
    S_GAP   = 5'b10000
  } sched_state_t;

  localparam int unsigned BANK_W          = 2;
  localparam int unsigned ROW_W           = 12;
  localparam int unsigned COL_W           = 8;
  localparam int unsigned SDRAM_ADDR_W    = BANK_W + ROW_W + COL_W;
  localparam int unsigned DEFAULT_TIMEOUT = 4096;

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin picker: first valid client after ptr, wrapping modulo NUM_REQ.
module sdram_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any_valid,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    any_valid = |req_valid;
    winner    = '0;
    idx       = '0;
    // Scan from the farthest candidate back toward ptr+1 so the nearest valid client is kept.
    for (int unsigned i = NUM_REQ; i >= 1; i--) begin
      idx = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (req_valid[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/sdram_req_sched.sv
// Round-robin burst request scheduler in front of the SDRAM read/write engine, with burst timeout.
module sdram_req_sched
  import sdram_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = SDRAM_ADDR_W,
  parameter int unsigned LEN_W   = 9,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                       sclk,
  input  logic                       srst,
  input  logic                       init_done,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         req_done,
  output logic                       cmd_trig,
  output logic                       cmd_wr,
  output logic [ADDR_W-1:0]          cmd_addr,
  output logic [LEN_W-1:0]           cmd_len,
  input  logic                       cmd_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err
);

  localparam int unsigned      IDX_W = $clog2(NUM_REQ);
  localparam int unsigned      CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  sched_state_t     state, next_state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             grant;
  logic             timeout_hit;
  logic [CNT_W-1:0] cnt;

  sdram_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .any_valid (pick_any),
    .winner    (pick_idx)
  );

  always_comb begin
    next_state  = state;
    grant       = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (init_done && pick_any) begin
          grant      = 1'b1;
          next_state = S_ISSUE;
        end
      end
      S_ISSUE: next_state = (cmd_len != '0) ? S_WAIT : S_DONE;
      S_WAIT: begin
        if (cmd_done) begin
          next_state = S_DONE;
        end else if (cnt == LIMIT) begin
          timeout_hit = 1'b1;
          next_state  = S_GAP;
        end
      end
      S_DONE:  next_state = S_GAP;
      S_GAP:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Pulses are registered one state ahead so they appear during ISSUE/DONE/GAP themselves.
  always_ff @(posedge sclk) begin
    if (srst) begin
      state       <= S_IDLE;
      ptr         <= IDX_W'(NUM_REQ - 1);
      cnt         <= '0;
      grant_id    <= '0;
      cmd_wr      <= 1'b0;
      cmd_addr    <= '0;
      cmd_len     <= '0;
      req_ready   <= '0;
      req_done    <= '0;
      cmd_trig    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= next_state;
      busy        <= (next_state != S_IDLE);
      req_ready   <= '0;
      req_done    <= '0;
      cmd_trig    <= 1'b0;
      timeout_err <= 1'b0;

      if (state == S_ISSUE || state == S_WAIT) cnt <= cnt + 1'b1;

      if (grant) begin
        grant_id  <= pick_idx;
        cmd_wr    <= req_wr[pick_idx];
        cmd_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
        cmd_len   <= req_len[pick_idx*LEN_W +: LEN_W];
        req_ready <= ONE << pick_idx;
        cmd_trig  <= (req_len[pick_idx*LEN_W +: LEN_W] != '0);
        cnt       <= '0;
      end

      if (next_state == S_DONE) req_done <= ONE << grant_id;
      if (timeout_hit) timeout_err <= 1'b1;
      if (state == S_DONE || timeout_hit) ptr <= grant_id;
    end
  end

endmodule

// File: tb/tb_sdram_req_sched.sv
// Bench for sdram_req_sched: directed scenarios plus random traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_sdram_req_sched;

  localparam int N  = 4;
  localparam int AW = 22;
  localparam int LW = 9;
  localparam int TO = 24;

  logic            sclk      = 1'b0;
  logic            srst      = 1'b1;
  logic            init_done = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    req_ready, req_done;
  logic            cmd_trig, cmd_wr;
  logic [AW-1:0]   cmd_addr;
  logic [LW-1:0]   cmd_len;
  logic            cmd_done  = 1'b0;
  logic            busy;
  logic [1:0]      grant_id;
  logic            timeout_err;

  logic          c_wr   [N];
  logic [AW-1:0] c_addr [N];
  logic [LW-1:0] c_len  [N];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int m_ptr  = N - 1;
  int w, t, t_prev, d;
  int exp_order [5] = '{0, 1, 2, 3, 0};

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_wr[g]              = c_wr[g];
    assign req_addr[g*AW +: AW]   = c_addr[g];
    assign req_len[g*LW +: LW]    = c_len[g];
  end

  sdram_req_sched #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .LEN_W   (LW),
    .TIMEOUT (TO)
  ) dut (
    .sclk        (sclk),
    .srst        (srst),
    .init_done   (init_done),
    .req_valid   (req_valid),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .req_ready   (req_ready),
    .req_done    (req_done),
    .cmd_trig    (cmd_trig),
    .cmd_wr      (cmd_wr),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cmd_done    (cmd_done),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Round-robin rule: first requesting client after the last served one, wrapping.
  function automatic int rr_pick(input int p, input logic [N-1:0] mask);
    for (int j = 1; j <= N; j++)
      if (mask[(p + j) % N]) return (p + j) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Called at a falling edge while the scheduler is idle; ends at the falling edge where it is idle again.
  // dly: cycles from cmd_trig to the cmd_done pulse; 0 or >= TO means the burst is left to time out.
  task automatic run_burst(input int dly, output int wi, output int t_trig);
    logic [N-1:0] mask;
    int  done_k, err_k, end_k;
    bit  zero;
    mask = req_valid & {N{init_done}};
    wi   = rr_pick(m_ptr, mask);
    if (wi < 0) begin
      $display("FAIL run_burst: called with no pending request");
      $fatal(1);
    end
    zero = (c_len[wi] == '0);
    @(negedge sclk);
    t_trig = cyc;
    chk("req_ready", req_ready, onehot(wi));
    chk("grant_id", grant_id, wi);
    chk("cmd_trig", cmd_trig, !zero);
    chk("cmd_wr", cmd_wr, c_wr[wi]);
    chk("cmd_addr", cmd_addr, c_addr[wi]);
    chk("cmd_len", cmd_len, c_len[wi]);
    chk("busy_issue", busy, 1);
    req_valid[wi] = 1'b0;
    if (zero) begin
      done_k = 1; err_k = -1; end_k = 3;
    end else if (dly >= 1 && dly < TO) begin
      done_k = dly + 1; err_k = -1; end_k = dly + 3;
    end else begin
      done_k = -1; err_k = TO; end_k = TO + 1;
    end
    for (int k = 1; k <= end_k; k++) begin
      @(negedge sclk);
      chk("req_done", req_done, (k == done_k) ? onehot(wi) : '0);
      chk("timeout_err", timeout_err, k == err_k);
      chk("no_trig_ready", {cmd_trig, req_ready}, 0);
      chk("busy", busy, k < end_k);
      cmd_done = !zero && (k < end_k) && (k == dly);
    end
    chk("cmd_hold", {cmd_wr, cmd_addr, cmd_len}, {c_wr[wi], c_addr[wi], c_len[wi]});
    m_ptr = wi;
  endtask

  task automatic new_fields(input int i, input bit allow_zero);
    c_wr[i]   = 1'($urandom);
    c_addr[i] = AW'($urandom);
    if (allow_zero && $urandom_range(0, 3) == 0) c_len[i] = '0;
    else c_len[i] = LW'($urandom_range(1, 511));
  endtask

  initial begin
    for (int i = 0; i < N; i++) new_fields(i, 1'b0);

    // Reset state
    repeat (3) @(negedge sclk);
    chk("reset_outputs",
        {req_ready, req_done, cmd_trig, cmd_wr, cmd_addr, cmd_len, busy, grant_id, timeout_err}, 0);
    srst = 1'b0;

    // No grants before init completes
    req_valid = '1;
    repeat (4) begin
      @(negedge sclk);
      chk("no_grant_before_init", {req_ready, busy, cmd_trig}, 0);
    end
    init_done = 1'b1;

    // Continuous requests from all clients: strict rotation, 14-cycle trig spacing
    for (int i = 0; i < 5; i++) begin
      req_valid = '1;
      run_burst(10, w, t);
      chk("rr_order", w, exp_order[i]);
      if (i > 0) chk("trig_spacing", t - t_prev, 14);
      t_prev = t;
      new_fields(w, 1'b0);
    end
    req_valid = '0;

    // Single write burst from client 2
    c_wr[2] = 1'b1; c_addr[2] = 22'h012345; c_len[2] = 9'd8;
    req_valid = 4'b0100;
    run_burst(20, w, t);
    chk("single_grant", w, 2);

    // Zero-length request from client 1, then ptr must sit on 1
    c_len[1] = '0;
    req_valid = 4'b0010;
    run_burst(5, w, t);
    new_fields(0, 1'b0); new_fields(2, 1'b0);
    req_valid = 4'b0101;
    run_burst(3, w, t);
    chk("ptr_after_zero_len", w, 2);

    // Timeout on client 3, next grant to client 0; done at TO-1 wins; done at TO lands in GAP
    for (int i = 1; i < N; i++) new_fields(i, 1'b0);
    req_valid = '1;
    run_burst(0, w, t);
    chk("timeout_client", w, 3);
    run_burst(6, w, t);
    chk("after_timeout_grant", w, 0);
    run_burst(TO - 1, w, t);
    run_burst(TO, w, t);
    req_valid = '0;

    // Reset in the middle of a burst
    c_wr[2] = 1'b0; c_addr[2] = 22'h2ABCD; c_len[2] = 9'd16;
    req_valid = 4'b0100;
    @(negedge sclk);
    chk("rst_mid_ready", req_ready, 4'b0100);
    req_valid = '0;
    repeat (4) @(negedge sclk);
    chk("rst_mid_busy", busy, 1);
    srst = 1'b1;
    @(negedge sclk);
    chk("rst_mid_outputs",
        {req_ready, req_done, cmd_trig, cmd_wr, cmd_addr, cmd_len, busy, grant_id, timeout_err}, 0);
    srst = 1'b0;
    cmd_done = 1'b1;
    @(negedge sclk);
    cmd_done = 1'b0;
    chk("late_done_ignored", {req_done, req_ready, busy, timeout_err}, 0);
    m_ptr = N - 1;
    for (int i = 0; i < N; i++) new_fields(i, 1'b0);
    req_valid = '1;
    run_burst(4, w, t);
    chk("first_after_reset", w, 0);
    req_valid = '0;

    // Random traffic: new requests, withdrawals, zero lengths, random completion/timeouts
    for (int it = 0; it < 40; it++) begin
      for (int j = 0; j < N; j++) begin
        if (!req_valid[j] && $urandom_range(0, 1) == 1) begin
          new_fields(j, 1'b1);
          req_valid[j] = 1'b1;
        end else if (req_valid[j] && $urandom_range(0, 7) == 0) begin
          req_valid[j] = 1'b0;
        end
      end
      if (req_valid == '0) begin
        @(negedge sclk);
        chk("idle_no_grant", {req_ready, busy, cmd_trig}, 0);
      end else begin
        d = ($urandom_range(0, 5) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(1, TO - 1);
        run_burst(d, w, t);
      end
    end

    req_valid = '0;
    repeat (2) @(negedge sclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
